// File: rtl/enc_pkg.sv
// enc_pkg: shared helpers for the enc_prio_rr priority encoder.
// Option macro ENC_PRIO_RR_EN is consumed by enc_prio_rr, not here.
package enc_pkg;

  localparam int MAX_N    = 64;
  localparam int IDX_MAXW = 6;

  typedef logic [MAX_N-1:0]    vec_t;
  typedef logic [IDX_MAXW-1:0] idx_t;

  // Lowest set bit position; returns 0 for an all-zero vector.
  function automatic idx_t lowest_set(input vec_t v);
    idx_t r;
    r = '0;
    for (int i = MAX_N - 1; i >= 0; i--) begin
      if (v[i]) r = idx_t'(i);
    end
    return r;
  endfunction

  // True when two or more bits are set.
  function automatic logic multi_hot(input vec_t v);
    return (v & (v - vec_t'(1))) != '0;
  endfunction

  // Index to one-hot vector.
  function automatic vec_t idx2onehot(input idx_t i);
    return vec_t'(1) << i;
  endfunction

endpackage

// File: rtl/enc_fixed_prio.sv
// enc_fixed_prio: combinational lowest-index-wins encoder.
// Grant is all-zero when no request is present.
module enc_fixed_prio
  import enc_pkg::*;
#(
  parameter  int N     = 8,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  output logic [IDX_W-1:0] idx_o,
  output logic [N-1:0]     grant_o,
  output logic             any_o
);

  idx_t low;

  // Find the lowest requester and its one-hot form.
  always_comb begin
    low     = lowest_set(vec_t'(req_i));
    any_o   = |req_i;
    idx_o   = IDX_W'(low);
    grant_o = any_o ? N'(idx2onehot(low)) : '0;
  end

endmodule

// File: rtl/enc_prio_rr.sv
// enc_prio_rr: N-input priority encoder with a registered valid/ready output.
// ENC_PRIO_RR_EN adds the rr_mode port and round-robin pointer.
module enc_prio_rr
  import enc_pkg::*;
#(
  parameter  int N     = 8,
  localparam int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
`ifdef ENC_PRIO_RR_EN
  input  logic             rr_mode,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [N-1:0]     out_grant,
  output logic             out_multi
);

  logic             valid_q, valid_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N-1:0]     grant_q, grant_d;
  logic             multi_q, multi_d;

  logic             free, load, accept;

  logic [IDX_W-1:0] full_idx;
  logic [N-1:0]     full_grant;
  logic             full_any;

  logic [IDX_W-1:0] win_idx;
  logic [N-1:0]     win_grant;

  enc_fixed_prio #(.N(N)) u_full (
    .req_i   (req),
    .idx_o   (full_idx),
    .grant_o (full_grant),
    .any_o   (full_any)
  );

`ifdef ENC_PRIO_RR_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [N-1:0]     hi_mask;
  logic [IDX_W-1:0] hi_idx;
  logic [N-1:0]     hi_grant;
  logic             hi_any;

  // Pointer advances past the index being accepted this cycle.
  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      if (idx_q == IDX_W'(N - 1)) ptr_d = '0;
      else                        ptr_d = idx_q + 1'b1;
    end
  end

  // Keep only requests at or above the post-accept pointer.
  always_comb begin
    hi_mask = '0;
    for (int i = 0; i < N; i++) begin
      hi_mask[i] = req[i] && (IDX_W'(i) >= ptr_d);
    end
  end

  enc_fixed_prio #(.N(N)) u_hi (
    .req_i   (hi_mask),
    .idx_o   (hi_idx),
    .grant_o (hi_grant),
    .any_o   (hi_any)
  );

  // Round-robin prefers the upper slice, else wraps to the full search.
  always_comb begin
    win_idx   = full_idx;
    win_grant = full_grant;
    if (rr_mode && hi_any) begin
      win_idx   = hi_idx;
      win_grant = hi_grant;
    end
  end

  // Pointer register; survives mode changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`else
  // Fixed priority only: the unmasked search always wins.
  always_comb begin
    win_idx   = full_idx;
    win_grant = full_grant;
  end
`endif

  // Handshake decode and output-register next state.
  always_comb begin
    free    = !valid_q || out_ready;
    accept  = valid_q && out_ready;
    load    = free && full_any;
    valid_d = valid_q;
    idx_d   = idx_q;
    grant_d = grant_q;
    multi_d = multi_q;
    if (free) valid_d = full_any;
    if (load) begin
      idx_d   = win_idx;
      grant_d = win_grant;
      multi_d = multi_hot(vec_t'(req));
    end
  end

  // Single-entry holding register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      idx_q   <= '0;
      grant_q <= '0;
      multi_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      idx_q   <= idx_d;
      grant_q <= grant_d;
      multi_q <= multi_d;
    end
  end

  // Drive outputs straight from the register.
  always_comb begin
    out_valid = valid_q;
    out_idx   = idx_q;
    out_grant = grant_q;
    out_multi = multi_q;
  end

endmodule

// File: tb/tb_enc_prio_rr.sv
// tb_enc_prio_rr: directed and random checks of enc_prio_rr with N=4.
// Round-robin scenarios run only when ENC_PRIO_RR_EN is defined.
module tb_enc_prio_rr;

  localparam int N  = 4;
  localparam int IW = 2;

  logic          clk       = 1'b0;
  logic          rst       = 1'b0;
  logic [N-1:0]  req       = '0;
  logic          rr_mode   = 1'b0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [IW-1:0] out_idx;
  logic [N-1:0]  out_grant;
  logic          out_multi;

  int errors  = 0;
  int checks  = 0;
  bit started = 0;

  bit           m_valid = 0;
  int           m_idx   = 0;
  int           m_ptr   = 0;
  logic [N-1:0] m_grant = '0;
  bit           m_multi = 0;

  always #5 clk = ~clk;

  enc_prio_rr #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
`ifdef ENC_PRIO_RR_EN
    .rr_mode   (rr_mode),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_grant (out_grant),
    .out_multi (out_multi)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: search from the pointer, wrapping modulo N.
  always @(posedge clk or posedge rst) begin : model
    bit acc;
    int np;
    int w;
    int j;
    if (rst) begin
      m_valid <= 0;
      m_idx   <= 0;
      m_ptr   <= 0;
      m_grant <= '0;
      m_multi <= 0;
    end else begin
      acc = m_valid && out_ready;
      np  = acc ? (m_idx + 1) % N : m_ptr;
      m_ptr <= np;
      if (!m_valid || out_ready) begin
        if (req != 0) begin
          w = -1;
          for (int k = 0; k < N; k++) begin
            j = rr_mode ? (np + k) % N : k;
            if (w < 0 && req[j]) w = j;
          end
          m_valid <= 1;
          m_idx   <= w;
          m_grant <= N'(1 << w);
          m_multi <= $countones(req) > 1;
        end else begin
          m_valid <= 0;
        end
      end
    end
  end

  // Compare DUT to model each cycle on the falling edge.
  always @(negedge clk) begin
    if (started) begin
      chk("m_valid", int'(out_valid), int'(m_valid));
      chk("m_idx",   int'(out_idx),   m_idx);
      chk("m_grant", int'(out_grant), int'(m_grant));
      chk("m_multi", int'(out_multi), int'(m_multi));
    end
  end

  task automatic drive(input logic [N-1:0] r, input logic rdy);
    req       = r;
    out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string nm, input int v, input int idx,
                            input int g, input int mu);
    chk({nm, ".valid"}, int'(out_valid), v);
    chk({nm, ".idx"},   int'(out_idx),   idx);
    chk({nm, ".grant"}, int'(out_grant), g);
    chk({nm, ".multi"}, int'(out_multi), mu);
  endtask

  initial begin
    logic [N-1:0] r;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    started = 1;

    repeat (3) begin
      drive(4'b0000, 1'b1);
      expect_out("idle", 0, 0, 0, 0);
    end

    for (int i = 0; i < N; i++) begin
      drive(N'(1 << i), 1'b1);
      expect_out("sweep", 1, i, 1 << i, 0);
    end

    drive(4'b1010, 1'b1);
    expect_out("multi", 1, 1, 4'b0010, 1);

    drive(4'b0100, 1'b1);
    expect_out("stall_cap", 1, 2, 4'b0100, 0);
    repeat (3) begin
      drive(4'b0001, 1'b0);
      expect_out("stall_hold", 1, 2, 4'b0100, 0);
    end
    drive(4'b0001, 1'b1);
    expect_out("stall_rel", 1, 0, 4'b0001, 0);

`ifdef ENC_PRIO_RR_EN
    drive(4'b0000, 1'b1);
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    rr_mode = 1'b1;
    drive(4'b1001, 1'b1);
    expect_out("rr0", 1, 0, 4'b0001, 1);
    drive(4'b1001, 1'b1);
    expect_out("rr1", 1, 3, 4'b1000, 1);
    drive(4'b1001, 1'b1);
    expect_out("rr2", 1, 0, 4'b0001, 1);
    drive(4'b1001, 1'b1);
    expect_out("rr3", 1, 3, 4'b1000, 1);
`endif

    drive(4'b0100, 1'b1);
    expect_out("pre_rst", 1, 2, 4'b0100, 0);
    drive(4'b0100, 1'b0);
    expect_out("pre_rst_hold", 1, 2, 4'b0100, 0);
    #2 rst = 1'b1;
    #1;
    expect_out("async_rst", 0, 0, 0, 0);
    #3 rst = 1'b0;
    drive(4'b1001, 1'b1);
    expect_out("post_rst", 1, 0, 4'b0001, 1);

    repeat (600) begin
`ifdef ENC_PRIO_RR_EN
      if ($urandom % 16 == 0) rr_mode = ~rr_mode;
`endif
      if ($urandom % 4 == 0) r = '0;
      else r = N'($urandom_range(1, (1 << N) - 1));
      drive(r, ($urandom % 4) != 0);
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/enc_prio_rr.md
# enc_prio_rr

Parametrised N-input priority encoder with a registered, valid/ready-handshaked output and an optional round-robin fairness mode. It replaces the fixed 4:2 combinational encoder wherever request vectors come from multiple sources. Typical uses are interrupt-line encoding, request-to-index conversion and simple arbitration ahead of a shared resource. The output stage is a single-entry holding register, so a stalled consumer never loses an encoded result.

## Interface
- N, default 8: number of request inputs, N >= 2.
- IDX_W, default $clog2(N): index width, derived and not overridden.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  N  request vector, sampled when the output register is free.
- rr_mode  input  1  1 selects round-robin priority, 0 selects fixed priority. Present only with ENC_PRIO_RR_EN.
- out_valid  output  1  the output register holds a result.
- out_ready  input  1  the consumer accepts the result.
- out_idx  output  IDX_W  encoded index of the winning request.
- out_grant  output  N  one-hot form of out_idx.
- out_multi  output  1  more than one req bit was set at capture time.

## Operation
- Fixed priority: the lowest set index wins. For N=4, req=4'b0110 gives idx 1.
- Round-robin priority:
  - Search starts at pointer ptr and wraps upward through N-1 and then 0.
  - On each accepted transfer, ptr becomes out_idx+1 mod N. From N-1 it wraps to 0.
- Capture condition: load = (!out_valid || out_ready) && (req != 0).
  - On load, register idx, grant and multi, and set out_valid=1.
  - If (!out_valid || out_ready) and req==0, clear out_valid. idx, grant and multi hold their last values.
  - If out_valid && !out_ready, the whole output register holds and req is ignored.
- ptr updates only on an accepted transfer (out_valid && out_ready), never on capture alone.
- A change of rr_mode takes effect at the next capture. ptr is preserved across mode changes and is not reset by them.
- A single set bit gives out_multi=0. Two or more set bits give out_multi=1.

## Timing
- Latency: req sampled at edge k appears on out_* after edge k, i.e. one cycle.
- Throughput: one result per cycle while out_ready=1 and req != 0.
- Reset values: out_valid=0, out_idx=0, out_grant=0, out_multi=0, ptr=0.
- Asserting rst mid-transfer forces the reset values immediately, with no clock required. An unaccepted result is discarded.
- Accept and new capture in the same cycle: the new result replaces the old one back-to-back. ptr advances from the accepted idx, and the new search uses that updated ptr in the same cycle.

## Configuration
- ENC_PRIO_RR_EN defined:
  - rr_mode port and ptr register are present.
  - Round-robin is selectable at runtime.
- ENC_PRIO_RR_EN undefined:
  - rr_mode port and ptr register are absent.
  - Behaviour is identical to rr_mode=0 in every cycle.

## Structure
- Package enc_pkg holds:
  - the lowest-set-bit function,
  - the popcount>1 (multi-hot) function,
  - index-to-one-hot conversion.
- Sub-module enc_fixed_prio: combinational lowest-index encoder, parametrised by N, with outputs idx, grant and any.
  - Round-robin uses two instances: one on the req bits at or above ptr (masked), one on the full req vector (unmasked).
  - The masked result is used if any masked bit is set, otherwise the unmasked result.
  - Fixed-priority mode uses only the unmasked instance.

## Test plan
All scenarios use N=4.
- Reset then idle: req=0, out_ready=1 -> out_valid=0, out_idx=0, out_grant=0 every cycle.
- Fixed priority, one-hot sweep: req=1,2,4,8 on consecutive cycles with out_ready=1 -> out_idx=0,1,2,3 one cycle later each, with out_multi=0.
- Multi-hot, fixed priority: req=4'b1010 -> out_idx=1, out_grant=4'b0010, out_multi=1.
- Stall: capture req=4'b0100, then hold out_ready=0 for 3 cycles while req=4'b0001 -> out_idx stays 2 and out_valid stays 1. After out_ready=1, the next result has out_idx=0.
- Round-robin wrap (macro defined, rr_mode=1): req=4'b1001 held, out_ready=1 -> out_idx sequence 0,3,0,3. From ptr=3 the pointer wraps to 0.
- Async reset mid-stall: out_valid=1 with out_ready=0, then assert rst between clock edges -> all outputs are 0 immediately and ptr=0. The first capture after release with req=4'b1001 gives out_idx=0.
